// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES command sequencer.
// Contents: command opcodes, status codes returned to the host, FSM state type,
// and a helper that recognises valid command bytes.
package aes_ctrl_pkg;

  localparam logic [7:0] OP_KEY = 8'h4B;  // 'K'
  localparam logic [7:0] OP_ENC = 8'h45;  // 'E'
  localparam logic [7:0] OP_DEC = 8'h44;  // 'D'

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BADCMD = 8'hE0;
  localparam logic [7:0] ST_NOKEY  = 8'hE1;
  localparam logic [7:0] ST_FTMO   = 8'hE2;
  localparam logic [7:0] ST_CTMO   = 8'hE3;

  typedef enum logic [2:0] {
    IDLE,
    RX_PAYLOAD,
    AES_START,
    AES_WAIT,
    TX_STATUS,
    TX_DATA
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == OP_KEY) || (b == OP_ENC) || (b == OP_DEC);
  endfunction

endpackage

// File: rtl/aes_byte_shifter.sv
// 16-byte shift register: serial-in/parallel-out for received payloads and
// parallel-in/serial-out for result bytes. Bytes enter at [7:0] and move up,
// so the first byte shifted in ends at [127:120]; the byte to send is always
// at [127:120].
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_clear       zero the byte count (data untouched)
//   i_load        parallel load i_load_data, zero the count
//   i_shift       shift i_byte in at the bottom, count one byte
//   o_data        current 128-bit contents
//   o_count       bytes shifted since clear/load, saturates at 16
//   o_done        o_count == 16
module aes_byte_shifter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [127:0] i_load_data,
  input  logic         i_shift,
  input  logic [7:0]   i_byte,
  output logic [127:0] o_data,
  output logic [4:0]   o_count,
  output logic         o_done
);

  logic [127:0] r_data;
  logic [4:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_data  <= i_load_data;
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_shift && !o_done) begin
      r_data  <= {r_data[119:0], i_byte};
      r_count <= r_count + 5'd1;
    end
  end

  assign o_data  = r_data;
  assign o_count = r_count;
  assign o_done  = (r_count == 5'd16);

endmodule

// File: rtl/aes_cmd_ctrl.sv
// Command sequencer between the UART byte stream and the AES core.
// Parses 'K'/'E'/'D' + 16-byte frames, drives the core, and answers with a
// status byte (plus 16 result bytes for successful E/D) over valid/ready.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_data, rx_valid          received byte and its one-cycle strobe
//   tx_data, tx_valid, tx_ready  outgoing byte handshake
//   aes_init, aes_next         one-cycle core start pulses
//   aes_encdec                 1 = encrypt, 0 = decrypt
//   aes_key                    {loaded key, 128'b0} (128-bit key mode)
//   aes_block                  block handed to the core
//   aes_ready, aes_result      core idle/done and its output
//   key_valid                  a key has been loaded and expanded
module aes_cmd_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 5000000,
  parameter int AES_WAIT_MAX = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         aes_init,
  output logic         aes_next,
  output logic         aes_encdec,
  output logic [255:0] aes_key,
  output logic [127:0] aes_block,
  input  logic         aes_ready,
  input  logic [127:0] aes_result,
  output logic         key_valid
);

  localparam int GAP_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam int WAIT_W = $clog2(AES_WAIT_MAX + 1);
  localparam logic [GAP_W-1:0]  GAP_LIMIT  = GAP_W'(TIMEOUT_CLKS);
  localparam logic [GAP_W-1:0]  GAP_ONE    = GAP_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(AES_WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_op, r_status;
  logic [127:0]        r_key;
  logic                r_key_valid;
  logic [GAP_W-1:0]    r_gap;
  logic [WAIT_W-1:0]   r_wait;

  logic         w_rx_clear, w_rx_shift, w_tx_load, w_tx_shift;
  logic         w_op_load, w_st_load, w_key_load, w_kv_clr, w_kv_set;
  logic [7:0]   w_st_val;
  logic [127:0] w_rx_buf, w_tx_buf;
  logic [4:0]   w_rx_cnt, w_tx_cnt;
  logic         w_rx_done, w_tx_done;
  logic         w_unused;

  aes_byte_shifter u_rx_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_rx_clear),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_shift     (w_rx_shift),
    .i_byte      (rx_data),
    .o_data      (w_rx_buf),
    .o_count     (w_rx_cnt),
    .o_done      (w_rx_done)
  );

  aes_byte_shifter u_tx_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (1'b0),
    .i_load      (w_tx_load),
    .i_load_data (aes_result),
    .i_shift     (w_tx_shift),
    .i_byte      (8'h00),
    .o_data      (w_tx_buf),
    .o_count     (w_tx_cnt),
    .o_done      (w_tx_done)
  );

  // Only the top byte of the TX buffer is ever sent.
  assign w_unused = ^{w_tx_buf[119:0], w_rx_done};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rx_clear  = 1'b0;
    w_rx_shift  = 1'b0;
    w_tx_load   = 1'b0;
    w_tx_shift  = 1'b0;
    w_op_load   = 1'b0;
    w_st_load   = 1'b0;
    w_st_val    = ST_OK;
    w_key_load  = 1'b0;
    w_kv_clr    = 1'b0;
    w_kv_set    = 1'b0;
    aes_init    = 1'b0;
    aes_next    = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    unique case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (is_cmd(rx_data)) begin
            w_op_load   = 1'b1;
            w_rx_clear  = 1'b1;
            w_state_nxt = RX_PAYLOAD;
          end else begin
            w_st_load   = 1'b1;
            w_st_val    = ST_BADCMD;
            w_state_nxt = TX_STATUS;
          end
        end
      end
      RX_PAYLOAD: begin
        // A byte on the expiry cycle wins over the timeout.
        if (rx_valid) begin
          w_rx_shift = 1'b1;
          if (w_rx_cnt == 5'd15) w_state_nxt = AES_START;
        end else if (r_gap == GAP_LIMIT) begin
          w_rx_clear  = 1'b1;
          w_st_load   = 1'b1;
          w_st_val    = ST_FTMO;
          w_state_nxt = TX_STATUS;
        end
      end
      AES_START: begin
        if (r_op == OP_KEY) begin
          w_key_load  = 1'b1;
          w_kv_clr    = 1'b1;
          aes_init    = 1'b1;
          w_state_nxt = AES_WAIT;
        end else if (!r_key_valid) begin
          w_st_load   = 1'b1;
          w_st_val    = ST_NOKEY;
          w_state_nxt = TX_STATUS;
        end else begin
          aes_next    = 1'b1;
          w_state_nxt = AES_WAIT;
        end
      end
      AES_WAIT: begin
        // The core drops ready one cycle after the pulse, so the first
        // AES_WAIT cycle (r_wait == 0) still shows the stale ready.
        if ((r_wait != '0) && aes_ready) begin
          w_st_load = 1'b1;
          w_st_val  = ST_OK;
          if (r_op == OP_KEY) w_kv_set  = 1'b1;
          else                w_tx_load = 1'b1;
          w_state_nxt = TX_STATUS;
        end else if (r_wait == WAIT_LIMIT) begin
          w_st_load   = 1'b1;
          w_st_val    = ST_CTMO;
          w_state_nxt = TX_STATUS;
        end
      end
      TX_STATUS: begin
        tx_valid = 1'b1;
        tx_data  = r_status;
        if (tx_ready) begin
          if ((r_status == ST_OK) && (r_op != OP_KEY)) w_state_nxt = TX_DATA;
          else                                         w_state_nxt = IDLE;
        end
      end
      TX_DATA: begin
        tx_valid = !w_tx_done;
        tx_data  = w_tx_buf[127:120];
        if (tx_ready) begin
          w_tx_shift = 1'b1;
          if (w_tx_cnt == 5'd15) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_status    <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_gap       <= '0;
      r_wait      <= '0;
    end else begin
      if (w_op_load)  r_op     <= rx_data;
      if (w_st_load)  r_status <= w_st_val;
      if (w_key_load) r_key    <= w_rx_buf;
      if (w_kv_clr)      r_key_valid <= 1'b0;
      else if (w_kv_set) r_key_valid <= 1'b1;
      if ((r_state == RX_PAYLOAD) && !rx_valid) r_gap <= r_gap + GAP_ONE;
      else                                      r_gap <= '0;
      if (r_state == AES_WAIT) r_wait <= r_wait + WAIT_ONE;
      else                     r_wait <= '0;
    end
  end

  // During the init pulse the core must already see the new key, before
  // r_key has captured it.
  assign aes_key    = {((r_state == AES_START) && (r_op == OP_KEY)) ? w_rx_buf : r_key,
                       128'h0};
  assign aes_encdec = (r_op == OP_ENC);
  assign aes_block  = w_rx_buf;
  assign key_valid  = r_key_valid;

endmodule

// File: tb/tb_aes_cmd_ctrl.sv
// Scoreboard bench for aes_cmd_ctrl with a behavioural AES core stub.
module tb_aes_cmd_ctrl;

  localparam int TMO  = 100;
  localparam int WMAX = 64;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic         aes_init, aes_next, aes_encdec;
  logic [255:0] aes_key;
  logic [127:0] aes_block;
  logic         aes_ready = 1'b1;
  logic [127:0] aes_result = 128'h0;
  logic         key_valid;

  aes_cmd_ctrl #(.TIMEOUT_CLKS(TMO), .AES_WAIT_MAX(WMAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .aes_init   (aes_init),
    .aes_next   (aes_next),
    .aes_encdec (aes_encdec),
    .aes_key    (aes_key),
    .aes_block  (aes_block),
    .aes_ready  (aes_ready),
    .aes_result (aes_result),
    .key_valid  (key_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  int pop_cnt = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: pops an expected byte on every TX handshake and
  // checks that a stalled byte stays put.
  logic       hold_chk = 1'b0;
  logic [7:0] hold_data = 8'h00;
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (hold_chk) begin
        chk("tx_hold_valid", {255'h0, tx_valid}, 256'd1);
        chk("tx_hold_data", {248'h0, tx_data}, {248'h0, hold_data});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected: got %02h with nothing expected", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", {248'h0, tx_data}, {248'h0, e});
          pop_cnt++;
        end
      end
      hold_chk  = tx_valid && !tx_ready;
      hold_data = tx_data;
    end else begin
      hold_chk = 1'b0;
    end
  end

  // Core pulse monitor
  int           init_cnt = 0, next_cnt = 0;
  logic [255:0] init_key = '0;
  logic         nx_encdec = 1'b0;
  logic [127:0] nx_block = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (aes_init) begin init_cnt++; init_key = aes_key; end
      if (aes_next) begin next_cnt++; nx_encdec = aes_encdec; nx_block = aes_block; end
    end
  end

  // Core stub: ready drops two half-cycles late, returns after c_lat cycles.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] b,
                                           input logic enc);
    if (k == KEY && enc && b == PT)  return CT;
    if (k == KEY && !enc && b == CT) return PT;
    return 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
  endfunction

  int           c_stage = 0, c_cnt = 0, c_lat = 5;
  logic         hang = 1'b0;
  logic [127:0] c_res = '0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aes_ready  = 1'b1;
      aes_result = 128'h0;
      c_stage    = 0;
    end else begin
      case (c_stage)
        0: if (aes_init || aes_next) begin
             c_res   = aes_next ? core_fn(aes_key[255:128], aes_block, aes_encdec) : aes_result;
             c_stage = 1;
           end
        1: c_stage = 2;
        2: begin aes_ready = 1'b0; c_cnt = c_lat; c_stage = 3; end
        default: if (!hang) begin
             c_cnt--;
             if (c_cnt <= 0) begin aes_ready = 1'b1; aes_result = c_res; c_stage = 0; end
           end
      endcase
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [127:0] d);
    send_byte(op);
    for (int i = 0; i < 16; i++) send_byte(d[127-8*i -: 8]);
  endtask

  task automatic push_block(input logic [127:0] d);
    for (int i = 0; i < 16; i++) exp_q.push_back(d[127-8*i -: 8]);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: %0d bytes still pending after %0d cycles", name, exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {251'h0, tx_valid, aes_init, aes_next, aes_encdec, key_valid}, 256'h0);
    chk({name, "_txd"}, {248'h0, tx_data}, 256'h0);
    chk({name, "_key"}, aes_key, 256'h0);
    chk({name, "_blk"}, {128'h0, aes_block}, 256'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ib, nb, pb, n;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Encrypt without a key
    nb = next_cnt;
    exp_q.push_back(8'hE1);
    send_frame(8'h45, PT);
    drain("nokey", 300);
    chk("nokey_no_next", next_cnt - nb, 0);

    // Unknown command
    exp_q.push_back(8'hE0);
    send_byte(8'h58);
    drain("badcmd", 100);

    // Key load
    ib = init_cnt;
    exp_q.push_back(8'h00);
    send_frame(8'h4B, KEY);
    drain("key_load", 300);
    chk("key_init_pulses", init_cnt - ib, 1);
    chk("key_at_init", init_key, {KEY, 128'h0});
    chk("key_valid_set", {255'h0, key_valid}, 256'd1);
    chk("key_out", aes_key, {KEY, 128'h0});

    // Encrypt FIPS-197 vector
    nb = next_cnt;
    exp_q.push_back(8'h00);
    push_block(CT);
    send_frame(8'h45, PT);
    drain("encrypt", 300);
    chk("enc_next_pulses", next_cnt - nb, 1);
    chk("enc_encdec", {255'h0, nx_encdec}, 256'd1);
    chk("enc_block", {128'h0, nx_block}, {128'h0, PT});

    // Decrypt with 50 cycles of TX backpressure mid-data
    pb = pop_cnt;
    exp_q.push_back(8'h00);
    push_block(PT);
    send_frame(8'h44, CT);
    n = 0;
    while (pop_cnt < pb + 4 && n < 300) begin @(posedge clk); n++; end
    chk("bp_reached_data", {255'h0, (pop_cnt >= pb + 4)}, 256'd1);
    @(posedge clk); #1 tx_ready = 1'b0;
    repeat (50) @(posedge clk);
    #1 tx_ready = 1'b1;
    drain("decrypt", 300);
    chk("dec_encdec", {255'h0, nx_encdec}, 256'd0);
    chk("dec_block", {128'h0, nx_block}, {128'h0, CT});

    // Frame timeout, then a normal key frame
    exp_q.push_back(8'hE2);
    send_byte(8'h45);
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    drain("frame_timeout", 400);
    ib = init_cnt;
    exp_q.push_back(8'h00);
    send_frame(8'h4B, KEY);
    drain("key_after_tmo", 300);
    chk("tmo_key_init", init_cnt - ib, 1);
    chk("tmo_key_valid", {255'h0, key_valid}, 256'd1);

    // Reset while waiting on the core
    c_lat = 40;
    send_frame(8'h45, PT);
    repeat (8) @(posedge clk);
    chk("pre_rst_key_valid", {255'h0, key_valid}, 256'd1);
    chk("pre_rst_encdec", {255'h0, aes_encdec}, 256'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("midwait_rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    c_lat = 5;
    repeat (2) @(posedge clk);

    // Core hang on key expansion
    hang = 1'b1;
    exp_q.push_back(8'hE3);
    send_frame(8'h4B, KEY);
    drain("core_timeout", 500);
    chk("ctmo_key_valid", {255'h0, key_valid}, 256'd0);
    hang = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
